w0rm_peripheral_irq_ctrl: RTL and testbench
===========================================

# w0rm_peripheral_irq_ctrl

Memory-mapped interrupt controller on the W0RM peripheral bus. It sits directly downstream of the counter peripheral and other event sources. It latches single-cycle event pulses such as `timer_reload` into per-source pending bits, masks them with a software-written enable register, and drives one level interrupt line to the CPU. Software services interrupts through a status/clear register and a priority-encoded vector register.

## Interface
- `ADDR_WIDTH`, 32, bus address width
- `DATA_WIDTH`, 32, bus data width
- `BASE_ADDR`, 32'h81000010, first byte of the 16-byte register window
- `N_SOURCES`, 8, number of event inputs; legal range 1..DATA_WIDTH-1
- `mem_clk`  in  1  sole clock; all flops rise on posedge
- `cpu_reset_n`  in  1  reset; asynchronous assertion, active-low
- `mem_valid_i`  in  1  bus request strobe, one cycle per access
- `mem_read_i`  in  1  read qualifier
- `mem_write_i`  in  1  write qualifier
- `mem_addr_i`  in  ADDR_WIDTH  byte address
- `mem_data_i`  in  DATA_WIDTH  write data
- `mem_valid_o`  out  1  response strobe
- `mem_data_o`  out  DATA_WIDTH  read data
- `irq_src_i`  in  N_SOURCES  event inputs; bit 0 is wired to the counter's `timer_reload`
- `cpu_irq_o`  out  1  level interrupt to the CPU

## Operation
- **Decode.** An access is selected when `mem_addr_i` is in [BASE_ADDR, BASE_ADDR+16). The offset is `mem_addr_i[3:0]`. Only offsets 0x0, 0x4, 0x8 and 0xC are mapped. Any other offset reads 0 and ignores writes.
- **0x0 STATUS (`pending`).** Reads return the pending bits, zero-extended. Writes are write-1-to-clear per bit.
- **0x4 ENABLE.** Read/write mask; bits [N_SOURCES-1:0] are used.
- **0x8 MODE.** Read/write, one bit per source.
  - 0 = level: the pending bit is set on every cycle `irq_src_i[k]`=1.
  - 1 = rising edge: the pending bit is set only when `irq_src_i[k]`=1 and `prev[k]`=0.
- **0xC VECTOR.** Read-only; writes are ignored.
  - Bit 31 = `|(pending & enable)`.
  - Bits [clog2(N_SOURCES)-1:0] = index of the lowest-numbered bit set in `pending & enable`.
  - All other bits read 0. The index field is 0 when bit 31 = 0.
- **Edge history.** `prev` is updated from `irq_src_i` every cycle, unconditionally.
- **Set/clear conflict.** If a set event and a write-1-clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- **Reads.** All reads return register values from before that cycle's update.
- **Read and write in one access.** If both `mem_read_i` and `mem_write_i` are high, the read returns the old value and the write is applied.
- **Interrupt output.** `cpu_irq_o` = `|(pending & enable)`. It is built only from flops; there is no combinational path from `irq_src_i` or the bus.
- **Masking.** Disabled sources still set their pending bits. Enabling such a source later raises `cpu_irq_o`.
- **Write data width.** Bits of `mem_data_i` above N_SOURCES-1 are ignored on writes to 0x0, 0x4 and 0x8.

## Timing
- **Reset.** While `cpu_reset_n`=0, all of the following are forced to 0 immediately, with no clock required:
  - registers `pending`, `enable`, `mode` and `prev`;
  - outputs `mem_valid_o`, `mem_data_o` and `cpu_irq_o`.
- **Reset release.** Operation starts on the first posedge after deassertion. Because `prev` resets to 0, a source held high through reset counts as an edge on the first clock.
- **Bus response.**
  - `mem_valid_o` is 1 exactly one cycle after a cycle with `mem_valid_i`=1 and the address selected, for both reads and writes; otherwise it is 0.
  - `mem_data_o` is valid in that same cycle.
  - `mem_data_o` is 0 for write-only and unselected accesses.
  - Back-to-back accesses are supported every cycle.
- **Event latency.** An event sampled at edge n sets `pending` at edge n. `cpu_irq_o` is high in cycle n+1, i.e. one cycle after the input is seen.
- **Clear latency.** A clear write sampled at edge n drops `pending`, and therefore `cpu_irq_o`, after edge n. This applies unless a same-cycle set occurs.
- **Enable latency.** A write to ENABLE takes effect on `cpu_irq_o` the cycle after the write edge.
- **Reset mid-access.** Any in-flight response is discarded; `mem_valid_o` drops to 0 immediately.

## Test plan
- **Reset.** Assert `cpu_reset_n`=0 mid-access with `mem_valid_o`=1. Required: `mem_valid_o`, `mem_data_o` and `cpu_irq_o` go to 0 without a clock edge, and all four registers read 0 after release.
- **Edge mode.** Write MODE=0x01 and ENABLE=0x01. Drive `irq_src_i[0]` high for 3 cycles. Required: STATUS=0x01, `cpu_irq_o`=1 one cycle after the first high cycle, VECTOR=0x80000000. Then write 0x01 to STATUS. Required: `cpu_irq_o`=0 the next cycle and STATUS=0.
- **Level mode and masking.** Set MODE=0 and ENABLE=0, then hold `irq_src_i[3]`=1. Required: STATUS=0x08 and `cpu_irq_o`=0. Then write ENABLE=0x08. Required: `cpu_irq_o`=1 the next cycle and VECTOR=0x80000003. With the source still high, clearing bit 3 leaves STATUS=0x08.
- **Priority.** Drive pending sources 2, 5 and 7, all enabled. Required: VECTOR=0x80000002. After clearing bit 2, VECTOR=0x80000005.
- **Set/clear conflict.** In edge mode, make a rising edge on source 1 land in the same cycle as a write of 0x02 to STATUS. Required: STATUS still reads 0x02.
- **Bus decode.** Read at BASE_ADDR+0x10 and at BASE_ADDR-4. Required: no `mem_valid_o`. Read at offset 0xC with both read and write high and data 0xFFFFFFFF. Required: the old value is returned and VECTOR is unchanged. Issue back-to-back reads of offsets 0x0, 0x4 and 0x8. Required: three consecutive `mem_valid_o` pulses with the correct data.

Source files
------------

// File: rtl/w0rm_peripheral_irq_ctrl_if.sv
// W0RM peripheral bus: single-cycle request strobe and fixed one-cycle response.
interface w0rm_peripheral_irq_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Handshake: a request is taken in any cycle mem_valid_i=1 (no backpressure);
    // a selected request is answered by mem_valid_o=1 exactly one cycle later.
    logic                  mem_valid_i;
    logic                  mem_read_i;
    logic                  mem_write_i;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [DATA_WIDTH-1:0] mem_data_i;
    logic                  mem_valid_o;
    logic [DATA_WIDTH-1:0] mem_data_o;

    modport master (
        output mem_valid_i, mem_read_i, mem_write_i, mem_addr_i, mem_data_i,
        input  mem_valid_o, mem_data_o
    );

    modport slave (
        input  mem_valid_i, mem_read_i, mem_write_i, mem_addr_i, mem_data_i,
        output mem_valid_o, mem_data_o
    );
endinterface

// File: rtl/w0rm_peripheral_irq_ctrl.sv
// Interrupt controller: latches event pulses into pending bits, masks them with
// ENABLE, and exposes STATUS/ENABLE/MODE/VECTOR on the W0RM peripheral bus.
module w0rm_peripheral_irq_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h81000010,
    parameter int                    N_SOURCES  = 8
) (
    input  logic                       mem_clk,
    input  logic                       cpu_reset_n,
    w0rm_peripheral_irq_ctrl_if.slave  bus,
    input  logic [N_SOURCES-1:0]       irq_src_i,
    output logic                       cpu_irq_o
);
    localparam int IW = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;

    logic [N_SOURCES-1:0]  pending, enable, mode, prev;
    logic [N_SOURCES-1:0]  pending_nxt, enable_nxt, mode_nxt;
    logic [N_SOURCES-1:0]  set_vec, clr_vec, masked, wdata_src;
    logic [ADDR_WIDTH-1:0] rel_addr;
    logic [3:0]            off;
    logic                  sel;
    logic                  wr_status, wr_enable, wr_mode;
    logic                  any_irq;
    logic [IW-1:0]         vec_idx;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  unused_wdata;

    // Subtracting the base keeps the window test correct even near address wrap.
    assign rel_addr  = bus.mem_addr_i - BASE_ADDR;
    assign sel       = bus.mem_valid_i && (rel_addr < ADDR_WIDTH'(16));
    assign off       = bus.mem_addr_i[3:0];
    assign wdata_src = bus.mem_data_i[N_SOURCES-1:0];

    assign unused_wdata = ^bus.mem_data_i[DATA_WIDTH-1:N_SOURCES];

    assign wr_status = sel && bus.mem_write_i && (off == 4'h0);
    assign wr_enable = sel && bus.mem_write_i && (off == 4'h4);
    assign wr_mode   = sel && bus.mem_write_i && (off == 4'h8);

    // Level sources set every cycle; edge sources only when prev was low.
    assign set_vec     = irq_src_i & ~(mode & prev);
    assign clr_vec     = wr_status ? wdata_src : '0;
    assign pending_nxt = (pending & ~clr_vec) | set_vec;
    assign enable_nxt  = wr_enable ? wdata_src : enable;
    assign mode_nxt    = wr_mode ? wdata_src : mode;

    assign masked  = pending & enable;
    assign any_irq = |masked;

    always_comb begin
        vec_idx = '0;
        for (int k = N_SOURCES - 1; k >= 0; k--) begin
            if (masked[k]) vec_idx = IW'(k);
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            4'h0: rdata[N_SOURCES-1:0] = pending;
            4'h4: rdata[N_SOURCES-1:0] = enable;
            4'h8: rdata[N_SOURCES-1:0] = mode;
            4'hC: begin
                rdata[DATA_WIDTH-1] = any_irq;
                rdata[IW-1:0]       = vec_idx;
            end
            default: rdata = '0;
        endcase
    end

    // cpu_irq_o is registered from next-state values so it tracks pending/enable
    // flops exactly while having no combinational path from inputs.
    always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            pending        <= '0;
            enable         <= '0;
            mode           <= '0;
            prev           <= '0;
            bus.mem_valid_o <= 1'b0;
            bus.mem_data_o  <= '0;
            cpu_irq_o      <= 1'b0;
        end else begin
            pending        <= pending_nxt;
            enable         <= enable_nxt;
            mode           <= mode_nxt;
            prev           <= irq_src_i;
            bus.mem_valid_o <= sel;
            bus.mem_data_o  <= (sel && bus.mem_read_i) ? rdata : '0;
            cpu_irq_o      <= |(pending_nxt & enable_nxt);
        end
    end
endmodule

// File: tb/tb_w0rm_peripheral_irq_ctrl.sv
// Bench for w0rm_peripheral_irq_ctrl: directed vector table, reset corner
// sequence, and randomized traffic against a bit-level reference model.
module tb_w0rm_peripheral_irq_ctrl;
  localparam logic [31:0] B = 32'h81000010;

  logic       mem_clk = 1'b0;
  logic       cpu_reset_n = 1'b1;
  logic [7:0] irq_src_i = '0;
  logic       cpu_irq_o;

  w0rm_peripheral_irq_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  w0rm_peripheral_irq_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(B), .N_SOURCES(8)
  ) dut (
    .mem_clk(mem_clk),
    .cpu_reset_n(cpu_reset_n),
    .bus(bus),
    .irq_src_i(irq_src_i),
    .cpu_irq_o(cpu_irq_o)
  );

  // clock / reset
  always #5 mem_clk = ~mem_clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit [7:0] m_pending, m_enable, m_mode, m_prev;
  bit       m_irq;
  bit       e_valid;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [7:0]  src;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_valid;
    logic [31:0] exp_data;
    bit          exp_irq;
  } vec_t;

  vec_t tbl[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic [7:0] src, bit rd, bit wr, logic [31:0] addr,
                              logic [31:0] wdata, bit ev, logic [31:0] ed, bit ei);
    vec_t v;
    v.src = src; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_valid = ev; v.exp_data = ed; v.exp_irq = ei;
    return v;
  endfunction

  function automatic void model_reset();
    m_pending = '0; m_enable = '0; m_mode = '0; m_prev = '0; m_irq = 1'b0;
    exp_q.delete();
  endfunction

  function automatic logic [31:0] model_vector();
    logic [31:0] r = '0;
    for (int k = 0; k < 8; k++) begin
      if (m_pending[k] && m_enable[k]) begin
        r = 32'h8000_0000 | k;
        break;
      end
    end
    return r;
  endfunction

  // One bus cycle of the model: computes the expected response, updates state.
  function automatic void model_cycle(logic [7:0] src, bit v, bit rd, bit wr,
                                      logic [31:0] addr, logic [31:0] wdata);
    longint unsigned a = addr;
    longint unsigned base = B;
    bit sel = v && (a >= base) && (a < base + 16);
    int off = int'(a - base);
    logic [31:0] val = '0;
    if (sel) begin
      case (off)
        0:  val = {24'h0, m_pending};
        4:  val = {24'h0, m_enable};
        8:  val = {24'h0, m_mode};
        12: val = model_vector();
        default: val = '0;
      endcase
    end
    e_valid = sel;
    if (sel) exp_q.push_back(rd ? val : 32'h0);
    for (int k = 0; k < 8; k++) begin
      bit ev = src[k] && (!m_mode[k] || !m_prev[k]);
      bit clr = sel && wr && (off == 0) && wdata[k];
      if (ev) m_pending[k] = 1'b1;
      else if (clr) m_pending[k] = 1'b0;
    end
    if (sel && wr && off == 4) m_enable = wdata[7:0];
    if (sel && wr && off == 8) m_mode = wdata[7:0];
    m_prev = src;
    m_irq = (m_pending & m_enable) != 0;
  endfunction

  // driver: apply one cycle, then check outputs #1 after the sampling edge
  task automatic drive_cycle(logic [7:0] src, bit rd, bit wr, logic [31:0] addr,
                             logic [31:0] wdata);
    logic [31:0] exp;
    bus.mem_valid_i = rd || wr;
    bus.mem_read_i  = rd;
    bus.mem_write_i = wr;
    bus.mem_addr_i  = addr;
    bus.mem_data_i  = wdata;
    irq_src_i       = src;
    model_cycle(src, rd || wr, rd, wr, addr, wdata);
    @(posedge mem_clk);
    #1;
    check("mem_valid_o", {31'h0, bus.mem_valid_o}, {31'h0, e_valid});
    if (bus.mem_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got response %h expected none", bus.mem_data_o);
      end else begin
        exp = exp_q.pop_front();
        check("mem_data_o", bus.mem_data_o, exp);
      end
    end else begin
      check("mem_data_o_idle", bus.mem_data_o, 32'h0);
    end
    check("cpu_irq_o", {31'h0, cpu_irq_o}, {31'h0, m_irq});
  endtask

  task automatic bus_idle();
    bus.mem_valid_i = 1'b0;
    bus.mem_read_i  = 1'b0;
    bus.mem_write_i = 1'b0;
    bus.mem_addr_i  = '0;
    bus.mem_data_i  = '0;
  endtask

  initial begin
    bus_idle();
    model_reset();

    // reset state
    #1 cpu_reset_n = 1'b0;
    #1;
    check("rst_valid", {31'h0, bus.mem_valid_o}, 32'h0);
    check("rst_data", bus.mem_data_o, 32'h0);
    check("rst_irq", {31'h0, cpu_irq_o}, 32'h0);
    repeat (2) @(posedge mem_clk);
    #1 cpu_reset_n = 1'b1;

    // directed vectors: {src, rd, wr, addr, wdata, exp_valid, exp_data, exp_irq}
    tbl.push_back(mk(8'h00, 0, 1, B + 8,  32'h01, 1, 32'h0, 0));
    tbl.push_back(mk(8'h00, 0, 1, B + 4,  32'h01, 1, 32'h0, 0));
    tbl.push_back(mk(8'h01, 0, 0, B,      32'h00, 0, 32'h0, 1));
    tbl.push_back(mk(8'h01, 0, 0, B,      32'h00, 0, 32'h0, 1));
    tbl.push_back(mk(8'h01, 0, 0, B,      32'h00, 0, 32'h0, 1));
    tbl.push_back(mk(8'h00, 1, 0, B,      32'h00, 1, 32'h1, 1));
    tbl.push_back(mk(8'h00, 1, 0, B + 12, 32'h00, 1, 32'h8000_0000, 1));
    tbl.push_back(mk(8'h00, 0, 1, B,      32'h01, 1, 32'h0, 0));
    tbl.push_back(mk(8'h00, 1, 0, B,      32'h00, 1, 32'h0, 0));
    tbl.push_back(mk(8'h00, 0, 1, B + 8,  32'h00, 1, 32'h0, 0));
    tbl.push_back(mk(8'h00, 0, 1, B + 4,  32'h00, 1, 32'h0, 0));
    tbl.push_back(mk(8'h08, 0, 0, B,      32'h00, 0, 32'h0, 0));
    tbl.push_back(mk(8'h08, 1, 0, B,      32'h00, 1, 32'h8, 0));
    tbl.push_back(mk(8'h08, 0, 1, B + 4,  32'h08, 1, 32'h0, 1));
    tbl.push_back(mk(8'h08, 1, 0, B + 12, 32'h00, 1, 32'h8000_0003, 1));
    tbl.push_back(mk(8'h08, 0, 1, B,      32'h08, 1, 32'h0, 1));
    tbl.push_back(mk(8'h00, 1, 0, B,      32'h00, 1, 32'h8, 1));
    tbl.push_back(mk(8'h00, 0, 1, B,      32'h08, 1, 32'h0, 0));
    tbl.push_back(mk(8'h00, 0, 1, B + 4,  32'hA4, 1, 32'h0, 0));
    tbl.push_back(mk(8'hA4, 0, 0, B,      32'h00, 0, 32'h0, 1));
    tbl.push_back(mk(8'h00, 1, 0, B + 12, 32'h00, 1, 32'h8000_0002, 1));
    tbl.push_back(mk(8'h00, 0, 1, B,      32'h04, 1, 32'h0, 1));
    tbl.push_back(mk(8'h00, 1, 0, B + 12, 32'h00, 1, 32'h8000_0005, 1));
    tbl.push_back(mk(8'h00, 0, 1, B,      32'hA0, 1, 32'h0, 0));
    tbl.push_back(mk(8'h00, 0, 1, B + 8,  32'h02, 1, 32'h0, 0));
    tbl.push_back(mk(8'h00, 0, 1, B + 4,  32'h02, 1, 32'h0, 0));
    tbl.push_back(mk(8'h02, 0, 1, B,      32'h02, 1, 32'h0, 1));
    tbl.push_back(mk(8'h02, 1, 0, B,      32'h00, 1, 32'h2, 1));
    tbl.push_back(mk(8'h00, 1, 0, B,      32'h00, 1, 32'h2, 1));
    tbl.push_back(mk(8'h00, 1, 0, B + 16, 32'h00, 0, 32'h0, 1));
    tbl.push_back(mk(8'h00, 1, 0, B - 4,  32'h00, 0, 32'h0, 1));
    tbl.push_back(mk(8'h00, 1, 1, B + 12, 32'hFFFF_FFFF, 1, 32'h8000_0001, 1));
    tbl.push_back(mk(8'h00, 1, 0, B + 12, 32'h00, 1, 32'h8000_0001, 1));
    tbl.push_back(mk(8'h00, 1, 0, B,      32'h00, 1, 32'h2, 1));
    tbl.push_back(mk(8'h00, 1, 0, B + 4,  32'h00, 1, 32'h2, 1));
    tbl.push_back(mk(8'h00, 1, 0, B + 8,  32'h00, 1, 32'h2, 1));
    tbl.push_back(mk(8'h00, 1, 0, B + 2,  32'h00, 1, 32'h0, 1));
    tbl.push_back(mk(8'h00, 0, 1, B + 2,  32'hFF, 1, 32'h0, 1));
    tbl.push_back(mk(8'h00, 0, 1, B + 4,  32'hFFFF_FF02, 1, 32'h0, 1));
    tbl.push_back(mk(8'h00, 1, 0, B + 4,  32'h00, 1, 32'h2, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive_cycle(tbl[i].src, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      check($sformatf("tbl_valid[%0d]", i), {31'h0, bus.mem_valid_o}, {31'h0, tbl[i].exp_valid});
      check($sformatf("tbl_data[%0d]", i), bus.mem_data_o, tbl[i].exp_data);
      check($sformatf("tbl_irq[%0d]", i), {31'h0, cpu_irq_o}, {31'h0, tbl[i].exp_irq});
    end

    // reset in the middle of a live response, with the interrupt line high
    drive_cycle(8'h00, 1, 0, B, 32'h0);
    check("pre_rst_valid", {31'h0, bus.mem_valid_o}, 32'h1);
    check("pre_rst_irq", {31'h0, cpu_irq_o}, 32'h1);
    bus_idle();
    #1 cpu_reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, bus.mem_valid_o}, 32'h0);
    check("mid_rst_data", bus.mem_data_o, 32'h0);
    check("mid_rst_irq", {31'h0, cpu_irq_o}, 32'h0);
    model_reset();
    repeat (2) @(posedge mem_clk);
    #1 cpu_reset_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      drive_cycle(8'h00, 1, 0, B + 32'(4 * r), 32'h0);
      check($sformatf("post_rst_reg[%0d]", r), bus.mem_data_o, 32'h0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [7:0]  src;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          sel_kind;
      int          op;
      src = 8'($urandom & $urandom);
      sel_kind = $urandom_range(0, 9);
      case (sel_kind)
        4:       addr = B + 32'($urandom_range(0, 15));
        5:       addr = B + 32'd16 + 32'($urandom_range(0, 15));
        6:       addr = B - 32'($urandom_range(1, 16));
        default: addr = B + 32'(4 * $urandom_range(0, 3));
      endcase
      op = $urandom_range(0, 3);
      wdata = $urandom;
      drive_cycle(src, op[0], op[1], addr, wdata);
    end

    bus_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
